hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 The module SHALL have exactly one clock and one reset; the reset is asynchronous and active-low.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- if_id_rs  input  5  Rs of the instruction in ID.
- if_id_rt  input  5  Rt of the instruction in ID.
- id_uses_rt  input  1  ID instruction reads Rt.
- id_branch  input  1  ID instruction is a branch resolved in ID.
- branch_taken  input  1  branch comparison in ID is taken; valid only with id_branch.
- id_ex_memread  input  1  EX instruction is a load.
- id_ex_regwrite  input  1  EX instruction writes a register.
- id_ex_regdst  input  5  EX destination register.
- ex_mem_memread  input  1  MEM instruction is a load.
- ex_mem_regdst  input  5  MEM destination register.
- dmem_req  input  1  data-memory access issued this cycle.
- dmem_ready  input  1  data memory completes this cycle.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID register write enable.
- id_ex_bubble  output  1  load a NOP into ID/EX.
- if_id_flush  output  1  clear IF/ID; squashes the wrong-path fetch.
- ex_mem_hold  output  1  freeze EX/MEM and MEM/WB.
- stall_count  output  16  saturating count of cycles with pc_write=0.

Function
REQ-003 The FSM SHALL have three states: RUN, BR_WAIT and MEM_WAIT. Outputs SHALL be combinational from the state and the current inputs.
REQ-004 Define match(r) = r!=0 && (r==if_id_rs || (id_uses_rt && r==if_id_rt)).
REQ-005 Define the hazard terms:
- load_use = id_ex_memread && match(id_ex_regdst).
- br_ex = id_branch && id_ex_regwrite && !id_ex_memread && match(id_ex_regdst).
- br_ld = id_branch && id_ex_memread && match(id_ex_regdst).
- br_mem = id_branch && ex_mem_memread && match(ex_mem_regdst).
REQ-006 The default outputs SHALL be pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, ex_mem_hold=0.
REQ-007 In RUN, dmem_req && !dmem_ready SHALL have top priority: pc_write=0, if_id_write=0, ex_mem_hold=1, id_ex_bubble=0. Next state SHALL be MEM_WAIT.
REQ-008 In MEM_WAIT, the REQ-007 freeze outputs SHALL be held every cycle until the cycle dmem_ready=1; that cycle SHALL still freeze. Next state SHALL be RUN.
REQ-009 In RUN, with no memory wait, load_use||br_ex||br_mem SHALL give pc_write=0, if_id_write=0, id_ex_bubble=1 for one cycle. Next state SHALL be RUN.
REQ-010 In RUN, br_ld SHALL give the REQ-009 outputs. Next state SHALL be BR_WAIT.
REQ-011 In BR_WAIT, the REQ-009 outputs SHALL be asserted unconditionally. Next state SHALL be RUN; a load-to-branch dependency therefore stalls exactly 2 cycles.
REQ-012 In BR_WAIT, dmem_req && !dmem_ready SHALL take priority. It SHALL give the REQ-007 outputs and go to MEM_WAIT; the pending branch stall is re-evaluated in RUN afterwards.
REQ-013 if_id_flush SHALL equal id_branch && branch_taken, only in RUN, with no stall or freeze that cycle. It is never asserted together with if_id_write=0.
REQ-014 stall_count SHALL increment by 1 on each rising edge where pc_write=0 and SHALL saturate at 16'hFFFF.
REQ-015 Register 0 SHALL never create a hazard.
REQ-016 Simultaneous load_use and branch_taken SHALL give the stall only; no flush.

Reset
REQ-017 rst_n=0 SHALL immediately, asynchronously force state=RUN and stall_count=0.
REQ-018 While rst_n=0, outputs SHALL be pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, ex_mem_hold=0.
REQ-019 Reset asserted mid-stall or mid-MEM_WAIT SHALL abandon the stall. The first cycle after release SHALL be RUN.

Verification
REQ-020 Load-use test: stimulus id_ex_memread=1, id_ex_regdst=8, if_id_rs=8. Required response: one cycle pc_write=0, id_ex_bubble=1, stall_count 0->1. The next cycle, with the inputs cleared, outputs return to defaults.
REQ-021 Load-to-branch test: stimulus id_branch=1, id_ex_memread=1, id_ex_regdst=9, if_id_rt=9, id_uses_rt=1. Required response: exactly 2 stall cycles (RUN->BR_WAIT->RUN), then with branch_taken=1 the following cycle gives if_id_flush=1.
REQ-022 Memory-wait test: stimulus dmem_req=1, dmem_ready=0 for 3 cycles, then dmem_ready=1. Required response: ex_mem_hold=1 and pc_write=0 for 4 cycles, id_ex_bubble=0 throughout, stall_count=4.
REQ-023 Zero-register test: stimulus id_ex_memread=1, id_ex_regdst=0, if_id_rs=0. Required response: no stall.
REQ-024 Reset mid-wait test: stimulus rst_n pulsed low during MEM_WAIT. Required response: stall_count=0, state RUN, default outputs the first cycle after release.
REQ-025 Saturation test: stimulus a stall held for 65540 cycles. Required response: stall_count holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle for the hazard/stall unit: hazard sources from ID/EX/MEM,
// data-memory handshake, and the stall/flush/freeze controls back to the pipeline.
interface hazard_stall_unit_if;
  logic [4:0]  if_id_rs;
  logic [4:0]  if_id_rt;
  logic        id_uses_rt;
  logic        id_branch;
  logic        branch_taken;
  logic        id_ex_memread;
  logic        id_ex_regwrite;
  logic [4:0]  id_ex_regdst;
  logic        ex_mem_memread;
  logic [4:0]  ex_mem_regdst;
  logic        dmem_req;
  logic        dmem_ready;

  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic        ex_mem_hold;
  logic [15:0] stall_count;

  modport master (
    output if_id_rs, if_id_rt, id_uses_rt, id_branch, branch_taken,
           id_ex_memread, id_ex_regwrite, id_ex_regdst,
           ex_mem_memread, ex_mem_regdst, dmem_req, dmem_ready,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_hold,
           stall_count
  );

  modport slave (
    input  if_id_rs, if_id_rt, id_uses_rt, id_branch, branch_taken,
           id_ex_memread, id_ex_regwrite, id_ex_regdst,
           ex_mem_memread, ex_mem_regdst, dmem_req, dmem_ready,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_hold,
           stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-in-ID hazard detection with data-memory wait freeze and a
// saturating stalled-cycle counter.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   RUN      | normal issue; detect hazards, memory waits and taken branches
//   BR_WAIT  | second bubble of a load-to-branch dependency
//   MEM_WAIT | data memory busy; whole pipeline frozen until dmem_ready
module hazard_stall_unit (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic load_use, br_ex, br_ld, br_mem, mem_wait;
  logic match_ex, match_mem;

  logic pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_hold;

  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  assign match_ex  = reg_match(hz.id_ex_regdst, hz.if_id_rs, hz.if_id_rt, hz.id_uses_rt);
  assign match_mem = reg_match(hz.ex_mem_regdst, hz.if_id_rs, hz.if_id_rt, hz.id_uses_rt);

  assign load_use = hz.id_ex_memread && match_ex;
  assign br_ex    = hz.id_branch && hz.id_ex_regwrite && !hz.id_ex_memread && match_ex;
  assign br_ld    = hz.id_branch && hz.id_ex_memread && match_ex;
  assign br_mem   = hz.id_branch && hz.ex_mem_memread && match_mem;
  assign mem_wait = hz.dmem_req && !hz.dmem_ready;

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    ex_mem_hold  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          ex_mem_hold = 1'b1;
          state_d     = MEM_WAIT;
        end else if (br_ld) begin
          // br_ld is a subset of load_use, so it must be tested first
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          state_d      = BR_WAIT;
        end else if (load_use || br_ex || br_mem) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end else begin
          if_id_flush = hz.id_branch && hz.branch_taken;
        end
      end

      BR_WAIT: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if (mem_wait) begin
          ex_mem_hold = 1'b1;
          state_d     = MEM_WAIT;
        end else begin
          id_ex_bubble = 1'b1;
          state_d      = RUN;
        end
      end

      MEM_WAIT: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        ex_mem_hold = 1'b1;
        if (hz.dmem_ready) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Reset presents a bubbled, non-advancing pipeline
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b0;
      ex_mem_hold  = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.ex_mem_hold  = ex_mem_hold;
  assign hz.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: hand-computed outputs and stall counts.
module tb_hazard_stall_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hazard_stall_unit_if hz ();

  hazard_stall_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic pc, input logic ifw,
                         input logic bub, input logic fl, input logic hold);
    chk({tag, ".pc_write"},     {31'd0, hz.pc_write},     {31'd0, pc});
    chk({tag, ".if_id_write"},  {31'd0, hz.if_id_write},  {31'd0, ifw});
    chk({tag, ".id_ex_bubble"}, {31'd0, hz.id_ex_bubble}, {31'd0, bub});
    chk({tag, ".if_id_flush"},  {31'd0, hz.if_id_flush},  {31'd0, fl});
    chk({tag, ".ex_mem_hold"},  {31'd0, hz.ex_mem_hold},  {31'd0, hold});
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] v);
    chk({tag, ".stall_count"}, {16'd0, hz.stall_count}, {16'd0, v});
  endtask

  task automatic clear_inputs();
    hz.if_id_rs       = 5'd0;
    hz.if_id_rt       = 5'd0;
    hz.id_uses_rt     = 1'b0;
    hz.id_branch      = 1'b0;
    hz.branch_taken   = 1'b0;
    hz.id_ex_memread  = 1'b0;
    hz.id_ex_regwrite = 1'b0;
    hz.id_ex_regdst   = 5'd0;
    hz.ex_mem_memread = 1'b0;
    hz.ex_mem_regdst  = 5'd0;
    hz.dmem_req       = 1'b0;
    hz.dmem_ready     = 1'b0;
  endtask

  // one rising edge, then step off it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst_n = 1'b0;

    // reset: taken branch must not flush while in reset
    hz.id_branch    = 1'b1;
    hz.branch_taken = 1'b1;
    #3;
    chk_out("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_cnt("reset", 16'd0);
    tick();
    chk_cnt("reset_edge", 16'd0);
    clear_inputs();
    #2;
    rst_n = 1'b1;
    tick();
    #1;
    chk_out("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("idle", 16'd0);

    // load-use on rs
    hz.id_ex_memread = 1'b1;
    hz.id_ex_regdst  = 5'd8;
    hz.if_id_rs      = 5'd8;
    #1;
    chk_out("load_use", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_cnt("load_use", 16'd1);
    clear_inputs();
    #1;
    chk_out("load_use_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_cnt("load_use_after", 16'd1);

    // register 0 never hazards
    hz.id_ex_memread = 1'b1;
    #1;
    chk_out("zero_reg", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // rt match ignored when rt is not read
    hz.id_ex_regdst = 5'd5;
    hz.if_id_rt     = 5'd5;
    hz.if_id_rs     = 5'd3;
    hz.id_uses_rt   = 1'b0;
    #1;
    chk_out("rt_unused", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    hz.id_uses_rt = 1'b1;
    #1;
    chk_out("rt_used", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_cnt("rt_used", 16'd2);
    clear_inputs();

    // ALU result feeding a branch; stall wins over the taken branch
    hz.id_branch      = 1'b1;
    hz.branch_taken   = 1'b1;
    hz.id_ex_regwrite = 1'b1;
    hz.id_ex_regdst   = 5'd4;
    hz.if_id_rs       = 5'd4;
    #1;
    chk_out("br_ex", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_cnt("br_ex", 16'd3);
    hz.id_ex_regwrite = 1'b0;
    #1;
    chk_out("br_taken", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_cnt("br_taken", 16'd3);
    clear_inputs();

    // load-to-branch: exactly two bubbles then the flush
    hz.id_branch     = 1'b1;
    hz.id_ex_memread = 1'b1;
    hz.id_ex_regdst  = 5'd9;
    hz.if_id_rt      = 5'd9;
    hz.id_uses_rt    = 1'b1;
    #1;
    chk_out("br_ld_1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_cnt("br_ld_1", 16'd4);
    hz.id_ex_memread = 1'b0;
    hz.id_ex_regdst  = 5'd0;
    #1;
    chk_out("br_ld_2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_cnt("br_ld_2", 16'd5);
    hz.branch_taken = 1'b1;
    #1;
    chk_out("br_ld_flush", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk_cnt("br_ld_flush", 16'd5);
    clear_inputs();

    // MEM-stage load feeding a branch; needs id_branch
    hz.ex_mem_memread = 1'b1;
    hz.ex_mem_regdst  = 5'd7;
    hz.if_id_rs       = 5'd7;
    #1;
    chk_out("mem_no_branch", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    hz.id_branch = 1'b1;
    #1;
    chk_out("br_mem", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_cnt("br_mem", 16'd6);
    clear_inputs();

    // memory wait: three busy cycles then ready, four frozen cycles
    hz.dmem_req = 1'b1;
    #1;
    chk_out("mem_wait_1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("mem_wait_2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("mem_wait_3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    hz.dmem_ready = 1'b1;
    #1;
    chk_out("mem_wait_4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clear_inputs();
    #1;
    chk_out("mem_wait_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("mem_wait_done", 16'd10);

    // memory wait arriving during BR_WAIT takes priority
    hz.id_branch     = 1'b1;
    hz.id_ex_memread = 1'b1;
    hz.id_ex_regdst  = 5'd12;
    hz.if_id_rs      = 5'd12;
    tick();
    clear_inputs();
    hz.dmem_req = 1'b1;
    #1;
    chk_out("brw_mem", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    hz.dmem_ready = 1'b1;
    #1;
    chk_out("brw_mem_ready", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clear_inputs();
    #1;
    chk_out("brw_mem_done", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("brw_mem_done", 16'd13);

    // reset pulse in the middle of MEM_WAIT
    hz.dmem_req = 1'b1;
    tick();
    chk_cnt("pre_rst", 16'd14);
    rst_n = 1'b0;
    #1;
    chk_cnt("mid_rst", 16'd0);
    chk_out("mid_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    clear_inputs();
    rst_n = 1'b1;
    #1;
    chk_out("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("post_rst_edge", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_cnt("post_rst_edge", 16'd0);

    // saturation: continuous load-use stall
    hz.id_ex_memread = 1'b1;
    hz.id_ex_regdst  = 5'd8;
    hz.if_id_rs      = 5'd8;
    repeat (65534) tick();
    chk_cnt("sat_minus1", 16'hFFFE);
    tick();
    chk_cnt("sat_reach", 16'hFFFF);
    repeat (5) tick();
    chk_cnt("sat_hold", 16'hFFFF);
    chk_out("sat_hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    clear_inputs();
    tick();
    chk_cnt("sat_release", 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
